sram_fetch_ctrl: RTL and testbench

SRAM_FETCH_CTRL -- requirements
Module: sram_fetch_ctrl

---
 rtl/sram_fetch_ctrl.sv | 120 ++++++++++++
 tb/tb_sram_fetch_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fetch_ctrl.sv
// rtl/sram_fetch_ctrl.sv - SRAM word fetcher feeding a packetizer through a 2-entry FIFO (optional err flag: SRAM_FETCH_ERR_EN)
module sram_fetch_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int PKT_WORDS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        word_count,
    output logic              sram_cs,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [15:0]       sram_rdata,
    output logic [15:0]       word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              pkt_last,
    output logic              busy,
    output logic              done
`ifdef SRAM_FETCH_ERR_EN
    ,
    output logic              err
`endif
);

    localparam int BEAT_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          remaining_q;
    logic [7:0]          out_left_q;
    logic                inflight_q;
    logic [15:0]         fifo_mem [2];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          count_q;
    logic [BEAT_W-1:0]   beat_q;

    logic                accept;
    logic                push;
    logic                pop;
    logic [2:0]          occupancy;

    assign accept     = (state_q == S_IDLE) && start;
    assign push       = inflight_q;
    assign word_valid = (count_q != 2'd0);
    assign pop        = word_valid && word_ready;
    // Slots already claimed once this cycle's pop is accounted for
    assign occupancy  = {2'b00, inflight_q} + {1'b0, count_q} - {2'b00, pop};
    assign sram_cs    = (state_q == S_FETCH) && (remaining_q != 8'd0) && (occupancy < 3'd2);
    assign sram_addr  = addr_q;
    assign word_out   = word_valid ? fifo_mem[rd_ptr_q] : 16'h0000;
    assign pkt_last   = word_valid && ((beat_q == BEAT_W'(PKT_WORDS - 1)) || (out_left_q == 8'd1));
    assign busy       = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);

    // Next-state selection for the transfer sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (word_count != 8'd0) ? S_FETCH : S_DONE;
            S_FETCH: if (sram_cs && (remaining_q == 8'd1)) state_d = S_DRAIN;
            S_DRAIN: if ((count_q == 2'd0) && !inflight_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Address/remaining counters, read pipeline, FIFO and beat tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            remaining_q <= 8'd0;
            out_left_q  <= 8'd0;
            inflight_q  <= 1'b0;
            fifo_mem[0] <= 16'h0000;
            fifo_mem[1] <= 16'h0000;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            beat_q      <= '0;
        end else begin
            if (accept) begin
                addr_q      <= base_addr;
                remaining_q <= word_count;
            end else if (sram_cs) begin
                addr_q      <= addr_q + 1'b1;
                remaining_q <= remaining_q - 8'd1;
            end
            if (accept)   out_left_q <= word_count;
            else if (pop) out_left_q <= out_left_q - 8'd1;
            inflight_q <= sram_cs;
            if (push) begin
                fifo_mem[wr_ptr_q] <= sram_rdata;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
            if (state_q == S_DONE) beat_q <= '0;
            else if (pop)          beat_q <= beat_q + 1'b1;
        end
    end

`ifdef SRAM_FETCH_ERR_EN
    // Sticky flag for a start request arriving while a transfer is active
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          err <= 1'b0;
        else if (start && (state_q != S_IDLE)) err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_sram_fetch_ctrl.sv
// tb/tb_sram_fetch_ctrl.sv - directed self-checking bench for sram_fetch_ctrl
module tb_sram_fetch_ctrl;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [7:0]    word_count = 8'd0;
    logic          sram_cs;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_rdata = 16'h0000;
    logic [15:0]   word_out;
    logic          word_valid;
    logic          word_ready = 1'b0;
    logic          pkt_last;
    logic          busy;
    logic          done;
`ifdef SRAM_FETCH_ERR_EN
    logic          err;
`endif

    int n_checks = 0;
    int n_fail = 0;

    sram_fetch_ctrl #(.ADDR_W(AW), .PKT_WORDS(16)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .sram_cs(sram_cs), .sram_addr(sram_addr),
        .sram_rdata(sram_rdata), .word_out(word_out), .word_valid(word_valid),
        .word_ready(word_ready), .pkt_last(pkt_last), .busy(busy), .done(done)
`ifdef SRAM_FETCH_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
        return {6'b101101, a};
    endfunction

    // SRAM model: one-cycle read latency
    always @(posedge clk) if (sram_cs) sram_rdata <= mem_word(sram_addr);

    int          cyc = 0;
    logic [15:0] words[$];
    bit          lasts[$];
    int          xcyc[$];
    logic [AW-1:0] addrs[$];
    int          cscyc[$];
    int          done_cnt, done_cyc, busy_cnt, cs_viol, hold_viol, start_cyc, outstanding;
    bit          prev_stall;
    logic [15:0] prev_word;

    // Observer, sampling mid-cycle
    always @(negedge clk) begin
        int p;
        cyc = cyc + 1;
        if (reset) begin
            p = (word_valid && word_ready) ? 1 : 0;
            if (start && start_cyc < 0) start_cyc = cyc;
            if (sram_cs) begin
                addrs.push_back(sram_addr);
                cscyc.push_back(cyc);
                if (outstanding - p >= 2) cs_viol = cs_viol + 1;
            end
            if (prev_stall && (!word_valid || word_out !== prev_word)) hold_viol = hold_viol + 1;
            if (p == 1) begin
                words.push_back(word_out);
                lasts.push_back(pkt_last);
                xcyc.push_back(cyc);
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (busy) busy_cnt = busy_cnt + 1;
            outstanding = outstanding + (sram_cs ? 1 : 0) - p;
            prev_stall = word_valid && !word_ready;
            prev_word  = word_out;
        end else begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end
    end

    task automatic clear_obs();
        words.delete(); lasts.delete(); xcyc.delete(); addrs.delete(); cscyc.delete();
        done_cnt = 0; done_cyc = -1; busy_cnt = 0; cs_viol = 0; hold_viol = 0; start_cyc = -1;
    endtask

    task automatic run_xfer(input logic [AW-1:0] b, input logic [7:0] n, input bit toggle,
                            input bit mid, output bit timed_out);
        clear_obs();
        @(posedge clk); #1;
        base_addr = b; word_count = n; start = 1'b1; word_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (toggle) word_ready = ~word_ready;
            if (mid && i == 3) begin
                start = 1'b1; base_addr = b + AW'(100); word_count = 8'd3;
            end else start = 1'b0;
            if (done_cnt != 0) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        word_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({sram_cs, word_valid, pkt_last, busy, done} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 00000", {sram_cs, word_valid, pkt_last, busy, done});
        end
        n_checks++;
        if ({sram_addr, word_out} !== '0) begin
            n_fail++; $display("FAIL reset_data got addr=%h word=%h want 0", sram_addr, word_out);
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        bit to; int bad;
        run_xfer(10'h010, 8'd16, 1'b0, 1'b0, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout got no done want done"); end
        n_checks++;
        if (addrs.size() != 16) begin n_fail++; $display("FAIL basic_cs_count got %0d want 16", addrs.size()); end
        bad = 0;
        foreach (addrs[i]) begin
            if (addrs[i] !== AW'(16 + i)) bad++;
            if (i > 0 && cscyc[i] != cscyc[i-1] + 1) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL basic_addr_seq got %0d errors want 0", bad); end
        bad = (words.size() == 16) ? 0 : 100;
        foreach (words[i]) begin
            if (words[i] !== mem_word(AW'(16 + i))) bad++;
            if (lasts[i] !== (i == 15)) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL basic_words got %0d errors (n=%0d) want 0", bad, words.size()); end
        n_checks++;
        if (xcyc.size() == 0 || xcyc[0] != start_cyc + 3) begin
            n_fail++; $display("FAIL basic_latency got first=%0d start=%0d want start+3", (xcyc.size() != 0) ? xcyc[0] : -1, start_cyc);
        end
        n_checks++;
        if (xcyc.size() != 16 || xcyc[xcyc.size()-1] - xcyc[0] != 15) begin
            n_fail++; $display("FAIL basic_no_bubble got n=%0d want 16 consecutive", xcyc.size());
        end
        n_checks++;
        if (done_cnt != 1 || xcyc.size() == 0 || done_cyc != xcyc[xcyc.size()-1] + 2) begin
            n_fail++; $display("FAIL basic_done got cnt=%0d cyc=%0d want cnt=1 at last+2", done_cnt, done_cyc);
        end
        n_checks++;
        if (busy_cnt != done_cyc - start_cyc - 1) begin
            n_fail++; $display("FAIL basic_busy got %0d want %0d", busy_cnt, done_cyc - start_cyc - 1);
        end
    endtask

    task automatic test_multi_packet();
        bit to; int bad;
        run_xfer(10'h100, 8'd20, 1'b0, 1'b0, to);
        bad = (words.size() == 20 && !to) ? 0 : 100;
        foreach (words[i]) begin
            if (words[i] !== mem_word(AW'(256 + i))) bad++;
            if (lasts[i] !== (i == 15 || i == 19)) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL multi_words got %0d errors (n=%0d) want 0", bad, words.size()); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL multi_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        bit to; int bad;
        run_xfer(10'h200, 8'd8, 1'b1, 1'b0, to);
        bad = (words.size() == 8 && !to) ? 0 : 100;
        foreach (words[i]) begin
            if (words[i] !== mem_word(AW'(512 + i))) bad++;
            if (lasts[i] !== (i == 7)) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_words got %0d errors (n=%0d) want 0", bad, words.size()); end
        n_checks++; if (cs_viol != 0) begin n_fail++; $display("FAIL bp_cs_full got %0d want 0", cs_viol); end
        n_checks++; if (hold_viol != 0) begin n_fail++; $display("FAIL bp_hold got %0d want 0", hold_viol); end
        n_checks++;
        if (done_cnt != 1 || addrs.size() != 8) begin
            n_fail++; $display("FAIL bp_done got done=%0d reads=%0d want 1 and 8", done_cnt, addrs.size());
        end
    endtask

    task automatic test_addr_wrap();
        bit to; int bad;
        run_xfer(10'h3FE, 8'd4, 1'b0, 1'b0, to);
        bad = (addrs.size() == 4 && words.size() == 4 && !to) ? 0 : 100;
        foreach (addrs[i]) if (addrs[i] !== AW'(32'h3FE + i)) bad++;
        foreach (words[i]) if (words[i] !== mem_word(AW'(32'h3FE + i))) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL wrap_seq got %0d errors (n=%0d) want 0", bad, addrs.size()); end
    endtask

    task automatic test_zero_count();
        bit to;
        run_xfer(10'h055, 8'd0, 1'b0, 1'b0, to);
        n_checks++;
        if (addrs.size() != 0 || words.size() != 0) begin
            n_fail++; $display("FAIL zero_access got reads=%0d words=%0d want 0", addrs.size(), words.size());
        end
        n_checks++;
        if (to || done_cnt != 1 || done_cyc != start_cyc + 1) begin
            n_fail++; $display("FAIL zero_done got cnt=%0d cyc=%0d want 1 at %0d", done_cnt, done_cyc, start_cyc + 1);
        end
        n_checks++; if (busy_cnt != 0) begin n_fail++; $display("FAIL zero_busy got %0d want 0", busy_cnt); end
    endtask

    task automatic test_start_ignored();
        bit to; int bad;
        run_xfer(10'h050, 8'd16, 1'b0, 1'b1, to);
        bad = (words.size() == 16 && addrs.size() == 16 && !to) ? 0 : 100;
        foreach (words[i]) if (words[i] !== mem_word(AW'(32'h50 + i))) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL ignore_words got %0d errors (n=%0d) want 0", bad, words.size()); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL ignore_done got %0d want 1", done_cnt); end
`ifdef SRAM_FETCH_ERR_EN
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", err); end
`endif
    endtask

    task automatic test_reset_abort();
        bit to; int bad; bit seen;
        clear_obs();
        @(posedge clk); #1;
        base_addr = 10'h080; word_count = 8'd16; start = 1'b1; word_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (words.size() >= 5) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL abort_progress got %0d words want 5", words.size()); end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({sram_cs, word_valid, pkt_last, busy, done, sram_addr, word_out} !== '0) begin
            n_fail++; $display("FAIL abort_outputs got cs=%b v=%b l=%b b=%b d=%b a=%h w=%h want 0",
                               sram_cs, word_valid, pkt_last, busy, done, sram_addr, word_out);
        end
`ifdef SRAM_FETCH_ERR_EN
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b want 0", err); end
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_done got done=%0d busy=%b want 0 0", done_cnt, busy);
        end
        run_xfer(10'h0C0, 8'd16, 1'b0, 1'b0, to);
        bad = (words.size() == 16 && !to && done_cnt == 1) ? 0 : 100;
        foreach (words[i]) begin
            if (words[i] !== mem_word(AW'(32'hC0 + i))) bad++;
            if (lasts[i] !== (i == 15)) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL abort_restart got %0d errors (n=%0d) want 0", bad, words.size()); end
    endtask

    initial begin
        clear_obs();
        #3;
        test_reset();
        test_basic();
        test_multi_packet();
        test_backpressure();
        test_addr_wrap();
        test_zero_count();
        test_start_ignored();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
